// File: rtl/axis_ram_writer.sv
// axis_ram_writer: buffers AXI4-Stream samples and writes them as fixed INCR bursts into a RAM ring
module axis_ram_writer #(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_base_addr,
    input  logic [15:0] cfg_buf_bursts,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] sts_write_ptr,
    output logic        sts_overflow,
    output logic        sts_resp_error
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(BURST_LEN);
    localparam int OFS = $clog2(BURST_LEN * 4);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   idx_q, idx_d, size_q, size_d, idx_nxt, idx_wrap, size_eff;
    logic [31:0]   base_q, base_d, ptr_q, ptr_d;
    logic          en_q, ovf_q, ovf_d, err_q, err_d;
    logic          rise, flush, push, pop;

    assign rise     = cfg_enable && !en_q;
    assign flush    = !cfg_enable && state_q == IDLE;
    assign s_axis_tready = aresetn && (cfg_enable ? cnt_q != CW'(FIFO_DEPTH) : state_q == IDLE);
    assign push     = cfg_enable && s_axis_tvalid && s_axis_tready;
    assign pop      = state_q == DATA && m_axi_wready;
    assign size_eff = size_q == '0 ? 16'd1 : size_q;
    assign idx_nxt  = idx_q + 16'd1;
    assign idx_wrap = idx_nxt == size_eff ? 16'd0 : idx_nxt;

    assign m_axi_awaddr   = base_q + (32'(idx_q) << OFS);
    assign m_axi_awlen    = 8'(BURST_LEN - 1);
    assign m_axi_awsize   = 3'b010;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awvalid  = state_q == ADDR;
    assign m_axi_wdata    = state_q == DATA ? mem_q[rd_q] : 32'd0;
    assign m_axi_wstrb    = 4'hF;
    assign m_axi_wvalid   = state_q == DATA;
    assign m_axi_wlast    = state_q == DATA && beat_q == BW'(BURST_LEN - 1);
    assign m_axi_bready   = state_q == RESP;
    assign sts_write_ptr  = ptr_q;
    assign sts_overflow   = ovf_q;
    assign sts_resp_error = err_q;

    // Next state for the burst FSM, FIFO pointers, ring position and sticky flags
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        cnt_d   = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        if (rise) begin
            base_d = cfg_base_addr;
            size_d = cfg_buf_bursts;
            idx_d  = '0;
            ptr_d  = '0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end
        if (cfg_enable && s_axis_tvalid && !s_axis_tready) ovf_d = 1'b1;
        case (state_q)
            IDLE: if (cfg_enable && cnt_q >= CW'(BURST_LEN)) state_d = ADDR;
            ADDR: if (m_axi_awready) begin
                state_d = DATA;
                beat_d  = '0;
            end
            DATA: if (m_axi_wready) begin
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(BURST_LEN - 1)) state_d = RESP;
            end
            RESP: if (m_axi_bvalid) begin
                if (m_axi_bresp != 2'b00) err_d = 1'b1;
                idx_d   = idx_wrap;
                ptr_d   = 32'(idx_wrap) << OFS;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            en_q    <= cfg_enable;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Sample storage; contents need no reset since pointers define validity
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_q] <= s_axis_tdata;
    end
endmodule

// File: tb/tb_axis_ram_writer.sv
// tb_axis_ram_writer: scoreboard bench driving samples and an AXI write slave model
module tb_axis_ram_writer;
    logic        aclk = 1'b0, aresetn = 1'b0, cfg_enable = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [15:0] cfg_buf_bursts = '0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tready;
    logic [31:0] m_axi_awaddr, m_axi_wdata, sts_write_ptr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst, m_axi_bresp = 2'b00;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready = 1'b0, m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
    logic        m_axi_bvalid = 1'b0, m_axi_bready, sts_overflow, sts_resp_error;

    logic [31:0] exp_addr[$], exp_data[$], exp_ptr[$];
    int n_cmp = 0, n_err = 0;
    int aw_delay = 0, w_mode = 0, err_at = -1, b_count = 0, w_beat = 0, aw_wait = 0;
    bit ptr_pending = 1'b0;

    axis_ram_writer dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable),
        .cfg_base_addr(cfg_base_addr), .cfg_buf_bursts(cfg_buf_bursts),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .sts_write_ptr(sts_write_ptr), .sts_overflow(sts_overflow), .sts_resp_error(sts_resp_error)
    );

    always #5 aclk = ~aclk;

    // Slave model: decides ready/valid for the next rising edge and scores every handshake
    initial begin : slave
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                m_axi_bresp   = 2'b00;
                exp_addr.delete();
                exp_data.delete();
                exp_ptr.delete();
                w_beat = 0;
                aw_wait = 0;
                ptr_pending = 1'b0;
            end else begin
                if (ptr_pending) begin
                    n_cmp++;
                    if (exp_ptr.size() == 0) begin
                        n_err++;
                        $display("FAIL ptr_unexpected: got %h expected none", sts_write_ptr);
                    end else if (sts_write_ptr !== exp_ptr[0]) begin
                        n_err++;
                        $display("FAIL write_ptr: got %h expected %h", sts_write_ptr, exp_ptr[0]);
                    end
                    if (exp_ptr.size() != 0) void'(exp_ptr.pop_front());
                    ptr_pending = 1'b0;
                end
                m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
                if (m_axi_awvalid) begin
                    n_cmp++;
                    if (exp_addr.size() == 0) begin
                        n_err++;
                        $display("FAIL aw_unexpected: got %h expected none", m_axi_awaddr);
                    end else if (m_axi_awaddr !== exp_addr[0]) begin
                        n_err++;
                        $display("FAIL awaddr: got %h expected %h", m_axi_awaddr, exp_addr[0]);
                    end
                    if (m_axi_awready) begin
                        if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                        aw_wait = 0;
                    end else aw_wait++;
                end
                m_axi_wready = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? ~m_axi_wready : 1'b0;
                if (m_axi_wvalid) begin
                    n_cmp++;
                    if (exp_data.size() == 0) begin
                        n_err++;
                        $display("FAIL w_unexpected: got %h expected none", m_axi_wdata);
                    end else if (m_axi_wdata !== exp_data[0]) begin
                        n_err++;
                        $display("FAIL wdata: got %h expected %h", m_axi_wdata, exp_data[0]);
                    end
                    n_cmp++;
                    if (m_axi_wlast !== (w_beat == 15)) begin
                        n_err++;
                        $display("FAIL wlast: got %b expected %b (beat %0d)", m_axi_wlast, w_beat == 15, w_beat);
                    end
                    if (m_axi_wready) begin
                        if (exp_data.size() != 0) void'(exp_data.pop_front());
                        w_beat = (w_beat + 1) % 16;
                    end
                end
                m_axi_bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
                m_axi_bvalid = m_axi_bready;
                if (m_axi_bvalid) begin
                    b_count++;
                    ptr_pending = 1'b1;
                end
            end
        end
    end

    task automatic push_samples(input int n, input logic [31:0] start);
        int i = 0, g = 0;
        while (i < n && g < 2000) begin
            @(negedge aclk);
            g++;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = start + i;
            if (s_axis_tready) begin
                exp_data.push_back(start + i);
                i++;
            end
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (i != n) begin
            n_err++;
            $display("FAIL push_timeout: got %0d accepted expected %0d", i, n);
        end
    endtask

    task automatic wait_bursts(input int target);
        int g = 0;
        while (b_count < target && g < 1000) begin
            @(negedge aclk);
            g++;
        end
        repeat (2) @(negedge aclk);
        n_cmp++;
        if (b_count < target) begin
            n_err++;
            $display("FAIL burst_timeout: got %0d bursts expected %0d", b_count, target);
        end
    endtask

    task automatic restart(input logic [31:0] base, input logic [15:0] bursts);
        @(negedge aclk);
        cfg_enable = 1'b0;
        @(negedge aclk);
        cfg_base_addr  = base;
        cfg_buf_bursts = bursts;
        cfg_enable     = 1'b1;
        @(negedge aclk);
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_addr.size() + exp_data.size() + exp_ptr.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained: got %0d/%0d/%0d pending expected 0/0/0", name,
                     exp_addr.size(), exp_data.size(), exp_ptr.size());
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        n_cmp++;
        if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, sts_overflow, sts_resp_error} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0000000", {s_axis_tready, m_axi_awvalid, m_axi_wvalid,
                     m_axi_wlast, m_axi_bready, sts_overflow, sts_resp_error});
        end
        n_cmp++;
        if ({m_axi_awaddr, m_axi_wdata, sts_write_ptr} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_values: got %h %h %h expected zeros", m_axi_awaddr, m_axi_wdata, sts_write_ptr);
        end
        n_cmp++;
        if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb} !== {8'd15, 3'b010, 2'b01, 4'hF}) begin
            n_err++;
            $display("FAIL constants: got %h %b %b %h expected 0f 010 01 f", m_axi_awlen, m_axi_awsize,
                     m_axi_awburst, m_axi_wstrb);
        end
        aresetn = 1'b1;
        #1;
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL tready_after_reset: got %b expected 1", s_axis_tready);
        end
    endtask

    task automatic test_basic;
        int b0 = b_count;
        restart(32'h1000_0000, 16'd4);
        exp_addr.push_back(32'h1000_0000);
        exp_ptr.push_back(32'h40);
        push_samples(16, 0);
        n_cmp++;
        if (m_axi_awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL awvalid_early: got %b expected 0", m_axi_awvalid);
        end
        @(negedge aclk);
        n_cmp++;
        if (m_axi_awvalid !== 1'b1) begin
            n_err++;
            $display("FAIL awvalid_rise: got %b expected 1", m_axi_awvalid);
        end
        wait_bursts(b0 + 1);
        check_drained("basic");
        n_cmp++;
        if (sts_write_ptr !== 32'h40) begin
            n_err++;
            $display("FAIL basic_ptr: got %h expected 00000040", sts_write_ptr);
        end
    endtask

    task automatic test_wrap;
        int b0 = b_count;
        restart(32'h2000_0000, 16'd2);
        exp_addr.push_back(32'h2000_0000);
        exp_addr.push_back(32'h2000_0040);
        exp_addr.push_back(32'h2000_0000);
        exp_ptr.push_back(32'h40);
        exp_ptr.push_back(32'h0);
        exp_ptr.push_back(32'h40);
        push_samples(48, 32'h100);
        wait_bursts(b0 + 3);
        check_drained("wrap");
    endtask

    task automatic test_backpressure;
        int b0 = b_count, acc = 0;
        restart(32'h3000_0000, 16'd8);
        aw_delay = 5;
        w_mode = 1;
        exp_addr.push_back(32'h3000_0000);
        exp_addr.push_back(32'h3000_0040);
        exp_ptr.push_back(32'h40);
        exp_ptr.push_back(32'h80);
        push_samples(32, 32'h200);
        wait_bursts(b0 + 2);
        check_drained("bp");
        aw_delay = 0;
        w_mode = 2;
        for (int k = 0; k < 4; k++) exp_addr.push_back(32'h3000_0080 + 32'h40 * k);
        for (int k = 0; k < 4; k++) exp_ptr.push_back(32'hC0 + 32'h40 * k);
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h300 + acc;
            if (s_axis_tready) begin
                exp_data.push_back(32'h300 + acc);
                acc++;
            end
        end
        n_cmp++;
        if (s_axis_tready !== 1'b0 || acc != 64) begin
            n_err++;
            $display("FAIL fifo_full: got tready=%b accepted=%0d expected tready=0 accepted=64", s_axis_tready, acc);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (sts_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set: got %b expected 1", sts_overflow);
        end
        w_mode = 0;
        wait_bursts(b0 + 6);
        check_drained("overflow");
        n_cmp++;
        if (sts_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky: got %b expected 1", sts_overflow);
        end
    endtask

    task automatic test_error;
        int b0 = b_count;
        restart(32'h4000_0000, 16'd4);
        err_at = b0 + 1;
        exp_addr.push_back(32'h4000_0000);
        exp_addr.push_back(32'h4000_0040);
        exp_ptr.push_back(32'h40);
        exp_ptr.push_back(32'h80);
        push_samples(16, 32'h400);
        wait_bursts(b0 + 1);
        n_cmp++;
        if (sts_resp_error !== 1'b0) begin
            n_err++;
            $display("FAIL err_early: got %b expected 0", sts_resp_error);
        end
        push_samples(16, 32'h410);
        wait_bursts(b0 + 2);
        check_drained("error");
        n_cmp++;
        if (sts_resp_error !== 1'b1 || sts_write_ptr !== 32'h80) begin
            n_err++;
            $display("FAIL err_set: got err=%b ptr=%h expected err=1 ptr=00000080", sts_resp_error, sts_write_ptr);
        end
        err_at = -1;
        restart(32'h4000_0000, 16'd4);
        n_cmp++;
        if ({sts_resp_error, sts_overflow} !== 2'b00 || sts_write_ptr !== 32'h0) begin
            n_err++;
            $display("FAIL err_clear: got err=%b ovf=%b ptr=%h expected 0 0 00000000", sts_resp_error,
                     sts_overflow, sts_write_ptr);
        end
    endtask

    task automatic test_disable_mid;
        int b0 = b_count, g = 0;
        restart(32'h5000_0000, 16'd4);
        exp_addr.push_back(32'h5000_0000);
        exp_ptr.push_back(32'h40);
        push_samples(20, 32'h500);
        while (w_beat < 5 && g < 200) begin
            @(negedge aclk);
            g++;
        end
        cfg_enable = 1'b0;
        wait_bursts(b0 + 1);
        n_cmp++;
        if (exp_data.size() != 4 || exp_addr.size() != 0) begin
            n_err++;
            $display("FAIL disable_beats: got %0d data %0d addr left expected 4 0", exp_data.size(), exp_addr.size());
        end
        exp_data.delete();
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready} !== 4'b0001) begin
            n_err++;
            $display("FAIL disable_idle: got %b expected 0001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready});
        end
        repeat (4) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hDEAD;
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        restart(32'h5000_0000, 16'd4);
        exp_addr.push_back(32'h5000_0000);
        exp_ptr.push_back(32'h40);
        push_samples(16, 32'h520);
        wait_bursts(b0 + 2);
        check_drained("flush");
    endtask

    task automatic test_reset_mid;
        int b0, g = 0;
        restart(32'h6000_0000, 16'd4);
        exp_addr.push_back(32'h6000_0000);
        push_samples(16, 32'h600);
        while (!m_axi_wvalid && g < 50) begin
            @(negedge aclk);
            g++;
        end
        repeat (3) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 5'b0 ||
            {m_axi_awaddr, m_axi_wdata, sts_write_ptr} !== 96'd0) begin
            n_err++;
            $display("FAIL async_reset: got %b %h %h %h expected all zero", {s_axis_tready, m_axi_awvalid,
                     m_axi_wvalid, m_axi_wlast, m_axi_bready}, m_axi_awaddr, m_axi_wdata, sts_write_ptr);
        end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected 0001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready});
        end
        b0 = b_count;
        restart(32'h6000_0000, 16'd4);
        exp_addr.push_back(32'h6000_0000);
        exp_ptr.push_back(32'h40);
        push_samples(16, 32'h700);
        wait_bursts(b0 + 1);
        check_drained("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_error();
        test_disable_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
